// File: rtl/memoria_t_a_pkg.sv
// Shared constants for the fire-control mode table and its inverse decoder.
package memoria_t_a_pkg;
  localparam logic [10:0] PATTERN_A = 11'b11111111111;
  localparam logic [10:0] PATTERN_B = 11'b11010001000;
  localparam logic        MODO_A    = 1'b0;
  localparam logic        MODO_B    = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } estado_t;
endpackage

// File: rtl/decodificador_t_a_if.sv
// Readback bus between the actuator word source and the mode decoder.
// Optional fault counter enabled by DECODIFICADOR_T_A_FALLAS_EN.
interface decodificador_t_a_if;
  logic [10:0] entrada;
  logic        valid_in;
  logic        adress_out;
  logic        adress_valid;
  logic        error;
  logic        busy;
`ifdef DECODIFICADOR_T_A_FALLAS_EN
  logic [7:0]  cuenta_fallas;
`endif

  modport master (
    output entrada, valid_in,
`ifdef DECODIFICADOR_T_A_FALLAS_EN
    input  cuenta_fallas,
`endif
    input  adress_out, adress_valid, error, busy
  );

  modport slave (
    input  entrada, valid_in,
`ifdef DECODIFICADOR_T_A_FALLAS_EN
    output cuenta_fallas,
`endif
    output adress_out, adress_valid, error, busy
  );
endinterface

// File: rtl/decodificador_t_a_comparador.sv
// Combinational pattern matcher: word -> (hit, mode index). A wins if both patterns coincide.
module comparador_patron
  import memoria_t_a_pkg::*;
#(
  parameter logic [10:0] PAT_A = memoria_t_a_pkg::PATTERN_A,
  parameter logic [10:0] PAT_B = memoria_t_a_pkg::PATTERN_B
) (
  input  logic [10:0] entrada,
  output logic        hit,
  output logic        idx
);
  logic hit_a, hit_b;

  assign hit_a = (entrada == PAT_A);
  assign hit_b = (entrada == PAT_B);
  assign hit   = hit_a | hit_b;
  assign idx   = hit_a ? MODO_A : (hit_b ? MODO_B : MODO_A);
endmodule

// File: rtl/decodificador_t_a.sv
// Mode decoder: word must repeat STABLE_CYCLES accepted samples before the index is reported.
// Define DECODIFICADOR_T_A_FALLAS_EN to add the saturating fault-entry counter.
module decodificador_t_a
  import memoria_t_a_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic [10:0] PATTERN_A     = memoria_t_a_pkg::PATTERN_A,
  parameter logic [10:0] PATTERN_B     = memoria_t_a_pkg::PATTERN_B
) (
  input  logic                clk,
  input  logic                reset,
  decodificador_t_a_if.slave  bus
);
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  estado_t    state;
  logic       candidate;
  logic [3:0] count;
  logic [3:0] cnt_inc;
  logic       hit, idx;

  comparador_patron #(.PAT_A(PATTERN_A), .PAT_B(PATTERN_B)) u_cmp (
    .entrada (bus.entrada),
    .hit     (hit),
    .idx     (idx)
  );

  assign cnt_inc = count + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      candidate        <= MODO_A;
      count            <= '0;
      bus.adress_out   <= MODO_A;
      bus.adress_valid <= 1'b0;
      bus.error        <= 1'b0;
      bus.busy         <= 1'b0;
`ifdef DECODIFICADOR_T_A_FALLAS_EN
      bus.cuenta_fallas <= '0;
`endif
    end else if (bus.valid_in) begin
      if (!hit) begin
        state            <= FAULT;
        count            <= '0;
        bus.error        <= 1'b1;
        bus.adress_valid <= 1'b0;
        bus.busy         <= 1'b0;
`ifdef DECODIFICADOR_T_A_FALLAS_EN
        if (state != FAULT && bus.cuenta_fallas != 8'hFF)
          bus.cuenta_fallas <= bus.cuenta_fallas + 8'd1;
`endif
      end else if (state == CHECK && idx == candidate) begin
        count <= cnt_inc;
        if (cnt_inc == STABLE) begin
          state            <= LOCKED;
          bus.adress_out   <= candidate;
          bus.adress_valid <= 1'b1;
          bus.busy         <= 1'b0;
        end
      end else if (state == LOCKED && idx == bus.adress_out) begin
        state <= LOCKED;
      end else if (STABLE == 4'd1) begin
        // A single sample is enough: skip CHECK entirely.
        state            <= LOCKED;
        candidate        <= idx;
        count            <= 4'd1;
        bus.adress_out   <= idx;
        bus.adress_valid <= 1'b1;
        bus.error        <= 1'b0;
        bus.busy         <= 1'b0;
      end else begin
        // New candidate (or restart); a previous lock stays visible meanwhile.
        state     <= CHECK;
        candidate <= idx;
        count     <= 4'd1;
        bus.error <= 1'b0;
        bus.busy  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_decodificador_t_a.sv
// Self-checking bench: directed scenarios plus random traffic against a run-length model.
module tb_decodificador_t_a;
  localparam int SC = 4;
  localparam logic [10:0] PA = 11'h7FF;
  localparam logic [10:0] PB = 11'b11010001000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  decodificador_t_a_if bus ();

  decodificador_t_a #(.STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: length of the current run of identical accepted matches.
  int run_len;
  bit run_idx, m_out, m_valid, m_err;
  int m_fallas;

  function automatic bit m_busy();
    return (run_len > 0) && (run_len < SC);
  endfunction

  function automatic logic [3:0] expv();
    return {m_out, m_valid, m_err, m_busy()};
  endfunction

  function automatic logic [3:0] obsv();
    return {bus.adress_out, bus.adress_valid, bus.error, bus.busy};
  endfunction

  task automatic model_clear();
    run_len = 0; run_idx = 0; m_out = 0; m_valid = 0; m_err = 0; m_fallas = 0;
  endtask

  task automatic model_sample(input logic [10:0] w);
    bit match, idx;
    match = (w == PA) || (w == PB);
    idx   = (w != PA) && (w == PB);
    if (!match) begin
      if (!m_err && m_fallas < 255) m_fallas++;
      m_err = 1; m_valid = 0; run_len = 0;
    end else begin
      m_err = 0;
      if (run_len > 0 && idx == run_idx) begin
        if (run_len < SC) run_len++;
      end else begin
        run_idx = idx; run_len = 1;
      end
      if (run_len == SC) begin
        m_out = run_idx; m_valid = 1;
      end
    end
  endtask

  task automatic drive(input logic [10:0] w, input bit v);
    bus.entrada  = w;
    bus.valid_in = v;
    @(posedge clk);
    if (v) model_sample(w);
    #1;
  endtask

  task automatic do_reset();
    bus.entrada  = PB;
    bus.valid_in = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    reset = 1'b0;
    bus.valid_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obsv() !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0000", obsv());
    end
`ifdef DECODIFICADOR_T_A_FALLAS_EN
    checks++;
    if (bus.cuenta_fallas !== 8'd0) begin
      errors++; $display("FAIL reset_fallas got=%0d exp=0", bus.cuenta_fallas);
    end
`endif
  endtask

  task automatic test_lock_a();
    for (int i = 0; i < SC; i++) begin
      drive(PA, 1'b1);
      checks++;
      if (obsv() !== expv()) begin
        errors++; $display("FAIL lock_a[%0d] got=%b exp=%b", i, obsv(), expv());
      end
    end
    checks++;
    if (obsv() !== 4'b0100) begin
      errors++; $display("FAIL lock_a_final got=%b exp=0100", obsv());
    end
  endtask

  task automatic test_switch_b();
    for (int i = 0; i < SC; i++) begin
      drive(PB, 1'b1);
      checks++;
      if (obsv() !== ((i < SC - 1) ? 4'b0101 : 4'b1100)) begin
        errors++; $display("FAIL switch_b[%0d] got=%b exp_model=%b", i, obsv(), expv());
      end
    end
  endtask

  task automatic test_fault();
    do_reset();
    drive(PA, 1'b1);
    drive(PA, 1'b1);
    drive(11'h000, 1'b1);
    checks++;
    if (obsv() !== 4'b0010) begin
      errors++; $display("FAIL fault_entry got=%b exp=0010", obsv());
    end
    for (int i = 0; i < SC; i++) begin
      drive(PB, 1'b1);
      checks++;
      if (obsv() !== expv()) begin
        errors++; $display("FAIL fault_recover[%0d] got=%b exp=%b", i, obsv(), expv());
      end
    end
    checks++;
    if (obsv() !== 4'b1100) begin
      errors++; $display("FAIL fault_relock got=%b exp=1100", obsv());
    end
  endtask

  task automatic test_valid_gaps();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(PA, (i % 2) == 0);
      checks++;
      if (bus.adress_valid !== (i == 6) || obsv() !== expv()) begin
        errors++; $display("FAIL valid_gaps[%0d] got=%b exp=%b", i, obsv(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) drive(PA, 1'b1);
    do_reset();
    checks++;
    if (obsv() !== 4'b0000) begin
      errors++; $display("FAIL reset_mid got=%b exp=0000", obsv());
    end
    for (int i = 0; i < SC; i++) begin
      drive(PA, 1'b1);
      checks++;
      if (bus.adress_valid !== (i == SC - 1)) begin
        errors++; $display("FAIL relock_after_reset[%0d] got=%b exp=%b", i, bus.adress_valid, (i == SC - 1));
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] w;
    int sel;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        sel = $urandom_range(0, 9);
        w = (sel < 4) ? PA : (sel < 8) ? PB : 11'($urandom);
        drive(w, $urandom_range(0, 3) != 0);
      end
      checks++;
      if (obsv() !== expv()) begin
        errors++; $display("FAIL random[%0d] got=%b exp=%b", i, obsv(), expv());
      end
`ifdef DECODIFICADOR_T_A_FALLAS_EN
      checks++;
      if (bus.cuenta_fallas !== 8'(m_fallas)) begin
        errors++; $display("FAIL random_fallas[%0d] got=%0d exp=%0d", i, bus.cuenta_fallas, m_fallas);
      end
`endif
    end
  endtask

`ifdef DECODIFICADOR_T_A_FALLAS_EN
  task automatic test_fallas();
    do_reset();
    for (int i = 0; i < 600; i++) drive((i % 2 == 0) ? PA : 11'h001, 1'b1);
    checks++;
    if (bus.cuenta_fallas !== 8'd255 || m_fallas != 255) begin
      errors++; $display("FAIL fallas_saturate got=%0d exp=255", bus.cuenta_fallas);
    end
  endtask
`endif

  initial begin
    bus.entrada  = '0;
    bus.valid_in = 1'b0;
    model_clear();
    test_reset();
    test_lock_a();
    test_switch_b();
    test_fault();
    test_valid_gaps();
    test_reset_mid();
    test_random();
`ifdef DECODIFICADOR_T_A_FALLAS_EN
    test_fallas();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
